// File: rtl/fx_dot_acc_q15.sv
// Streaming Q15 dot-product engine: multiply pairs, accumulate wide, emit one
// saturated Q15 result per frame of LEN pairs. Multiplier truncates toward -inf.

module fx_mul_q15 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);
    logic signed [31:0] full;

    always_comb begin
        full = $signed(a) * $signed(b);
        // -1 * -1 is the only product that overflows Q15
        if (a == 16'h8000 && b == 16'h8000) begin
            p = 16'h7FFF;
        end else begin
            p = full[30:15];
        end
    end
endmodule

module fx_dot_acc_q15 #(
    parameter int LEN   = 16,
    parameter int ACC_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_q15,
    output logic        out_sat,
    output logic        busy
);
    localparam int CW = $clog2(LEN) + 1;
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] Q_MIN = -ACC_W'(32768);

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        HOLD
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]               p_q, p_d;
    logic                      p_valid_q, p_valid_d;
    logic                      p_last_q, p_last_d;
    logic                      out_valid_q, out_valid_d;
    logic [15:0]               out_q15_q, out_q15_d;
    logic                      out_sat_q, out_sat_d;

    logic [15:0]               prod;
    logic                      accept;
    logic                      last_pair;
    logic signed [ACC_W-1:0]   p_ext;
    logic signed [ACC_W-1:0]   sum;

    fx_mul_q15 u_mul (
        .a(in_a),
        .b(in_b),
        .p(prod)
    );

    assign in_ready  = (state_q == ACC);
    assign accept    = in_valid && in_ready;
    assign last_pair = (count_q == CW'(LEN - 1));
    assign p_ext     = ACC_W'($signed(p_q));
    assign sum       = acc_q + p_ext;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        p_d         = accept ? prod : p_q;
        p_valid_d   = accept;
        p_last_d    = accept && last_pair;
        out_valid_d = out_valid_q;
        out_q15_d   = out_q15_q;
        out_sat_d   = out_sat_q;

        if (p_valid_q) begin
            acc_d = sum;
        end

        unique case (state_q)
            ACC: begin
                if (accept) begin
                    if (last_pair) begin
                        count_d = '0;
                        state_d = FLUSH;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                state_d = HOLD;
                if (p_valid_q && p_last_q) begin
                    if (sum > Q_MAX) begin
                        out_q15_d = 16'h7FFF;
                        out_sat_d = 1'b1;
                    end else if (sum < Q_MIN) begin
                        out_q15_d = 16'h8000;
                        out_sat_d = 1'b1;
                    end else begin
                        out_q15_d = sum[15:0];
                        out_sat_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                // result register settles one cycle before it is offered
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    state_d     = ACC;
                    acc_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            count_q     <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q15_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            out_valid_q <= out_valid_d;
            out_q15_q   <= out_q15_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_q15   = out_q15_q;
    assign out_sat   = out_sat_q;
    assign busy      = (count_q != '0) || (state_q != ACC) || p_valid_q;
endmodule

// File: tb/tb_fx_dot_acc_q15.sv
// Bench for fx_dot_acc_q15 with LEN=4: fixed vectors, corner sequences and
// random frames against an arithmetic dot-product model.

module tb_fx_dot_acc_q15;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_q15;
    logic        out_sat;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fx_dot_acc_q15 #(.LEN(4), .ACC_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_q15(out_q15),
        .out_sat(out_sat),
        .busy(busy)
    );

    typedef struct {
        logic [15:0] a[4];
        logic [15:0] b[4];
        logic [15:0] q;
        logic        sat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Q15 product: exact product scaled by 2^-15, rounded toward -inf, clamped
    function automatic int q15_mul(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        p = int'($floor(real'(p) / 32768.0));
        if (p > 32767) p = 32767;
        return p;
    endfunction

    task automatic model(input logic [15:0] a[4], input logic [15:0] b[4],
                         output logic [15:0] q, output logic sat);
        longint s = 0;
        for (int i = 0; i < 4; i++) s += q15_mul(a[i], b[i]);
        if (s > 32767) begin
            q = 16'h7FFF; sat = 1'b1;
        end else if (s < -32768) begin
            q = 16'h8000; sat = 1'b1;
        end else begin
            q = 16'(s); sat = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] a[4], input logic [15:0] b[4],
                             input int gapmax, input logic [15:0] eq,
                             input logic es, input string name);
        for (int i = 0; i < 4; i++)
            send(a[i], b[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
        chk({name, "_ov_n0"}, out_valid, 0);
        @(posedge clk); #1;
        chk({name, "_ov_n1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({name, "_ov_n2"}, out_valid, 1);
        chk({name, "_q"}, out_q15, eq);
        chk({name, "_sat"}, out_sat, es);
        chk({name, "_inrdy"}, in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_ov_drop"}, out_valid, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    initial begin
        vec_t        tbl[4];
        logic [15:0] ra[4];
        logic [15:0] rb[4];
        logic [15:0] eq;
        logic        es;
        logic [15:0] held;

        tbl[0].a = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        tbl[0].b = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        tbl[0].q = 16'h7FFF; tbl[0].sat = 1'b1;
        tbl[1].a = '{16'h4000, 16'hC000, 16'h4000, 16'h2000};
        tbl[1].b = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        tbl[1].q = 16'h3000; tbl[1].sat = 1'b0;
        tbl[2].a = '{16'hC000, 16'hC000, 16'hC000, 16'hC000};
        tbl[2].b = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        tbl[2].q = 16'h8000; tbl[2].sat = 1'b0;
        tbl[3].a = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        tbl[3].b = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tbl[3].q = 16'h8000; tbl[3].sat = 1'b1;

        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_q", out_q15, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_inrdy", in_ready, 1);

        for (int i = 0; i < 4; i++)
            run_frame(tbl[i].a, tbl[i].b, 0, tbl[i].q, tbl[i].sat,
                      $sformatf("vec%0d", i));

        // stall in HOLD with the next frame's first pair already offered
        run_frame(tbl[1].a, tbl[1].b, 0, 16'h3000, 1'b0, "pre_hold");
        for (int i = 0; i < 4; i++) send(16'h2000, 16'h4000, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("hold_ov", out_valid, 1);
        held = out_q15;
        chk("hold_q", held, 16'h4000);
        in_a = 16'h4000; in_b = 16'h4000; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("hold_stable", out_q15, held);
            chk("hold_inrdy", in_ready, 0);
            chk("hold_ovhi", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_release", out_valid, 0);
        ra = '{16'h4000, 16'h2000, 16'h2000, 16'h2000};
        rb = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        run_frame(ra, rb, 0, 16'h5000, 1'b0, "after_hold");

        // reset with a partial frame in flight
        send(16'h7000, 16'h7000, 0);
        send(16'h7000, 16'h7000, 0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_q", out_q15, 0);
        chk("mid_rst_sat", out_sat, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        ra = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
        model(ra, rb, eq, es);
        run_frame(ra, rb, 0, eq, es, "post_rst");

        // random frames, gaps, early out_ready
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 4; i++) begin
                if (f % 2 == 0) begin
                    ra[i] = 16'($urandom);
                    rb[i] = 16'($urandom);
                end else begin
                    ra[i] = 16'(int'($urandom_range(8191, 0)) - 4096);
                    rb[i] = 16'($urandom);
                end
            end
            if (f == 5) begin ra[0] = 16'h8000; rb[0] = 16'h8000; end
            model(ra, rb, eq, es);
            out_ready = (f % 3 == 0);
            run_frame(ra, rb, 3, eq, es, $sformatf("rnd%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=%0d", checks, 0);
        $fatal(1, "timeout");
    end
endmodule
